// File: rtl/imm_narrow.sv
`default_nettype none
// ============================================================================
// Module   : imm_narrow
// Purpose  : Narrows a 16-bit value to a 6-bit immediate field (signed or
//            unsigned range), flags out-of-range values, and counts delivered
//            overflow results with a saturating counter. One-entry output
//            register with valid/ready handshake on both sides.
// Config   : IMM_NARROW_SATURATE_EN -- when defined, out-of-range values are
//            clamped to the field limits; otherwise the low 6 bits pass through.
// Revision : 1.0 - initial release
// ============================================================================
module imm_narrow #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in16,
    input  logic             sign_extension_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out6,
    output logic             ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_in_ready;
    logic             w_accept;
    logic             w_deliver;
    logic             w_ovf_signed;
    logic             w_ovf_unsigned;
    logic             w_ovf;
    logic [5:0]       w_out6;

    logic             r_out_valid;
    logic [5:0]       r_out6;
    logic             r_ovf;
    logic [CNT_W-1:0] r_ovf_count;

    // Handshake: the output register can take a new value when empty or draining
    always_comb begin
        w_in_ready = !r_out_valid || out_ready;
        w_accept   = in_valid && w_in_ready;
        w_deliver  = r_out_valid && out_ready;
    end

    // Range check and narrowing of the incoming value
    always_comb begin
        // Signed field fits only when bits 15..5 are a pure sign extension
        w_ovf_signed   = !((&in16[15:5]) || !(|in16[15:5]));
        w_ovf_unsigned = |in16[15:6];
        w_ovf          = sign_extension_mode ? w_ovf_signed : w_ovf_unsigned;
        w_out6         = in16[5:0];
`ifdef IMM_NARROW_SATURATE_EN
        if (w_ovf) begin
            if (sign_extension_mode) begin
                w_out6 = in16[15] ? 6'h20 : 6'h1F;
            end else begin
                w_out6 = 6'h3F;
            end
        end
`endif
    end

    // One-entry result register; a new accept replaces a delivered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out6      <= 6'h00;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out6      <= w_out6;
            r_ovf       <= w_ovf;
        end else if (w_deliver) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of delivered overflow results; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (clr_count) begin
            r_ovf_count <= '0;
        end else if (w_deliver && r_ovf && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + c_cnt_one;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out6      = r_out6;
    assign ovf       = r_ovf;
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_narrow
// Purpose  : Directed self-checking bench for imm_narrow (CNT_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_narrow;

    localparam int CNT_W = 8;

`ifdef IMM_NARROW_SATURATE_EN
    localparam logic [5:0] c_e_0040_u = 6'h3F;
    localparam logic [5:0] c_e_8000_s = 6'h20;
    localparam logic [5:0] c_e_0020_s = 6'h1F;
`else
    localparam logic [5:0] c_e_0040_u = 6'h00;
    localparam logic [5:0] c_e_8000_s = 6'h00;
    localparam logic [5:0] c_e_0020_s = 6'h20;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in16;
    logic             sign_extension_mode;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out6;
    logic             ovf;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    int n_checks;
    int n_errors;

    imm_narrow #(.CNT_W(CNT_W)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in16                (in16),
        .sign_extension_mode (sign_extension_mode),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out6                (out6),
        .ovf                 (ovf),
        .clr_count           (clr_count),
        .ovf_count           (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: offer one value, check the registered result one cycle later
    task automatic xfer(input string tag, input logic [15:0] v, input logic m,
                        input logic [5:0] e6, input logic eovf);
        in_valid            = 1'b1;
        in16                = v;
        sign_extension_mode = m;
        out_ready           = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out6"},  {26'd0, out6},      {26'd0, e6});
        check({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eovf});
    endtask

    logic [15:0] vals [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in16 = 16'h0000;
        sign_extension_mode = 1'b0;
        out_ready = 1'b0;
        clr_count = 1'b0;
        vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h0013;
        vals[3] = 16'h0024; vals[4] = 16'h0035; vals[5] = 16'h003E;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_out6",      {26'd0, out6},      32'd0);
        check("rst_count",     {24'd0, ovf_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic narrowing, both modes
        xfer("ffff_s", 16'hFFFF, 1'b1, 6'h3F, 1'b0);
        check("cnt_zero", {24'd0, ovf_count}, 32'd0);
        xfer("0040_u", 16'h0040, 1'b0, c_e_0040_u, 1'b1);
        check("cnt_pre", {24'd0, ovf_count}, 32'd0);
        @(negedge clk);
        check("cnt_one", {24'd0, ovf_count}, 32'd1);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        xfer("ffff_u", 16'hFFFF, 1'b0, 6'h3F, 1'b1);
        xfer("8000_s", 16'h8000, 1'b1, c_e_8000_s, 1'b1);
        xfer("0020_s", 16'h0020, 1'b1, c_e_0020_s, 1'b1);
        xfer("001f_s", 16'h001F, 1'b1, 6'h1F, 1'b0);
        xfer("ffe0_s", 16'hFFE0, 1'b1, 6'h20, 1'b0);
        xfer("003f_u", 16'h003F, 1'b0, 6'h3F, 1'b0);
        @(negedge clk);
        check("cnt_four", {24'd0, ovf_count}, 32'd4);

        // Backpressure: stall 5 cycles, then drain in order
        begin
            int idx_in;
            int idx_out;
            idx_in  = 0;
            idx_out = 0;
            sign_extension_mode = 1'b0;
            for (int cyc = 0; cyc < 40 && idx_out < 6; cyc++) begin
                in_valid  = (idx_in < 6);
                in16      = (idx_in < 6) ? vals[idx_in] : 16'hFFFF;
                out_ready = (cyc >= 6);
                #1;
                if (cyc >= 1 && cyc <= 5) begin
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    check("stall_out6", {26'd0, out6}, {26'd0, vals[0][5:0]});
                end
                if (out_valid && out_ready) begin
                    check("bp_order", {26'd0, out6}, {26'd0, vals[idx_out][5:0]});
                    idx_out++;
                end
                if (in_valid && in_ready) idx_in++;
                @(negedge clk);
            end
            check("bp_all_in",  idx_in,  6);
            check("bp_all_out", idx_out, 6);
            in_valid = 1'b0;
            @(negedge clk);
            check("bp_count", {24'd0, ovf_count}, 32'd4);
        end

        // Saturation after 300 overflowing transfers
        in_valid = 1'b1;
        in16 = 16'h0040;
        sign_extension_mode = 1'b0;
        out_ready = 1'b1;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("cnt_sat", {24'd0, ovf_count}, 32'hFF);

        // Clear coincident with an overflow delivery
        xfer("clr_ovf", 16'h0040, 1'b0, c_e_0040_u, 1'b1);
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
        check("clr_count", {24'd0, ovf_count}, 32'd0);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("clr_hold", {24'd0, ovf_count}, 32'd0);
        xfer("8000_s2", 16'h8000, 1'b1, c_e_8000_s, 1'b1);
        @(negedge clk);
        check("cnt_after_clr", {24'd0, ovf_count}, 32'd1);

        // Asynchronous reset while a result is held
        in_valid = 1'b1;
        in16 = 16'h0040;
        sign_extension_mode = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("held_valid", {31'd0, out_valid}, 32'd1);
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ovf",   {31'd0, ovf},       32'd0);
        check("arst_out6",  {26'd0, out6},      32'd0);
        check("arst_count", {24'd0, ovf_count}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_valid", {31'd0, out_valid}, 32'd0);
        check("rel_count", {24'd0, ovf_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
